// File: rtl/vend_dispense_scheduler.sv
// Round-robin scheduler sharing one dispense motor between NUM_REQ selection panels.
// Optional per-product stock tracking and restock port are enabled by defining VEND_STOCK_EN.
module vend_dispense_scheduler #(
    parameter int unsigned NUM_REQ         = 2,
    parameter int unsigned CREDIT_W        = 4,
    parameter int unsigned DISPENSE_CYCLES = 4,
    parameter int unsigned PRICE0          = 1,
    parameter int unsigned PRICE1          = 2,
    parameter int unsigned PRICE2          = 3,
    parameter int unsigned PRICE3          = 3
`ifdef VEND_STOCK_EN
    ,
    parameter int unsigned STOCK_W         = 4,
    parameter int unsigned STOCK_INIT      = 3
`endif
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [2*NUM_REQ-1:0]         sel,
    input  logic [CREDIT_W*NUM_REQ-1:0]  credit,
`ifdef VEND_STOCK_EN
    input  logic                         restock_valid,
    input  logic [1:0]                   restock_prod,
    input  logic [STOCK_W-1:0]           restock_qty,
`endif
    output logic [NUM_REQ-1:0]           gnt,
    output logic                         motor_on,
    output logic [1:0]                   motor_prod,
    output logic                         done,
    output logic [CREDIT_W-1:0]          change,
    output logic                         reject,
    output logic [1:0]                   reject_reason
);

    localparam int unsigned IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned TW = $clog2(DISPENSE_CYCLES + 1);

    typedef enum logic [2:0] {StIdle, StCheck, StDispense, StDone, StReject} state_e;

    state_e                state_q, state_d;
    logic [IW-1:0]         rr_q, rr_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [1:0]            sel_q, sel_d;
    logic [CREDIT_W-1:0]   credit_q, credit_d;
    logic [TW-1:0]         timer_q, timer_d;
    logic [1:0]            reason_q, reason_d;
    logic                  pick_found;
    logic [IW-1:0]         pick_idx;
    logic [IW-1:0]         cand;
    logic                  stock_ok;
    logic [CREDIT_W-1:0]   price;
    logic [IW-1:0]         idx_next;

    always_comb begin
        case (sel_q)
            2'd0:    price = CREDIT_W'(PRICE0);
            2'd1:    price = CREDIT_W'(PRICE1);
            2'd2:    price = CREDIT_W'(PRICE2);
            default: price = CREDIT_W'(PRICE3);
        endcase
    end

    assign idx_next = (idx_q == IW'(NUM_REQ - 1)) ? '0 : idx_q + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= StIdle;
            rr_q     <= '0;
            idx_q    <= '0;
            sel_q    <= '0;
            credit_q <= '0;
            timer_q  <= '0;
            reason_q <= '0;
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            idx_q    <= idx_d;
            sel_q    <= sel_d;
            credit_q <= credit_d;
            timer_q  <= timer_d;
            reason_q <= reason_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        rr_d          = rr_q;
        idx_d         = idx_q;
        sel_d         = sel_q;
        credit_d      = credit_q;
        timer_d       = '0;
        reason_d      = reason_q;
        gnt           = '0;
        motor_on      = 1'b0;
        motor_prod    = '0;
        done          = 1'b0;
        change        = '0;
        reject        = 1'b0;
        reject_reason = '0;
        pick_found    = 1'b0;
        pick_idx      = '0;
        cand          = '0;

        if (state_q != StIdle) gnt[idx_q] = 1'b1;

        case (state_q)
            StIdle: begin
                // First requester at or after the rr pointer, wrapping around.
                for (int unsigned k = 0; k < NUM_REQ; k++) begin
                    cand = IW'((32'(rr_q) + k) % NUM_REQ);
                    if (!pick_found && req[cand]) begin
                        pick_found = 1'b1;
                        pick_idx   = cand;
                    end
                end
                if (pick_found) begin
                    idx_d    = pick_idx;
                    sel_d    = sel[2*pick_idx +: 2];
                    credit_d = credit[CREDIT_W*pick_idx +: CREDIT_W];
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (!stock_ok) begin
                    reason_d = 2'b10;
                    state_d  = StReject;
                end else if (credit_q < price) begin
                    reason_d = 2'b01;
                    state_d  = StReject;
                end else begin
                    state_d  = StDispense;
                end
            end
            StDispense: begin
                motor_on   = 1'b1;
                motor_prod = sel_q;
                if (timer_q == TW'(DISPENSE_CYCLES - 1)) state_d = StDone;
                else timer_d = timer_q + 1'b1;
            end
            StDone: begin
                done    = 1'b1;
                change  = credit_q - price;
                rr_d    = idx_next;
                state_d = StIdle;
            end
            StReject: begin
                reject        = 1'b1;
                reject_reason = reason_q;
                rr_d          = idx_next;
                state_d       = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

`ifdef VEND_STOCK_EN
    logic [STOCK_W-1:0] stock_q [4];
    logic [STOCK_W-1:0] stock_d [4];
    logic [STOCK_W:0]   sum;

    assign stock_ok = (stock_q[sel_q] != '0);

    // Restock saturates first, then a completing dispense of the same product takes one.
    always_comb begin
        sum = '0;
        for (int p = 0; p < 4; p++) begin
            stock_d[p] = stock_q[p];
            if (restock_valid && restock_prod == 2'(p)) begin
                sum        = {1'b0, stock_q[p]} + {1'b0, restock_qty};
                stock_d[p] = sum[STOCK_W] ? '1 : sum[STOCK_W-1:0];
            end
            if (state_q == StDone && sel_q == 2'(p)) stock_d[p] = stock_d[p] - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int p = 0; p < 4; p++) stock_q[p] <= STOCK_W'(STOCK_INIT);
        end else begin
            for (int p = 0; p < 4; p++) stock_q[p] <= stock_d[p];
        end
    end
`else
    assign stock_ok = 1'b1;
`endif

endmodule

// File: tb/tb_vend_dispense_scheduler.sv
// Bench for vend_dispense_scheduler: transaction-timeline model checked every cycle plus
// hand-computed directed expectations. Stock checks are built when VEND_STOCK_EN is defined.
module tb_vend_dispense_scheduler;

    localparam int N  = 2;
    localparam int CW = 4;
    localparam int D  = 4;
`ifdef VEND_STOCK_EN
    localparam bit STOCK_EN = 1'b1;
`else
    localparam bit STOCK_EN = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [2*N-1:0]  sel;
    logic [CW*N-1:0] credit;
    logic [N-1:0]    gnt;
    logic            motor_on;
    logic [1:0]      motor_prod;
    logic            done;
    logic [CW-1:0]   change;
    logic            reject;
    logic [1:0]      reject_reason;
`ifdef VEND_STOCK_EN
    logic            restock_valid;
    logic [1:0]      restock_prod;
    logic [3:0]      restock_qty;
`endif

    vend_dispense_scheduler #(
        .NUM_REQ(N),
        .CREDIT_W(CW),
        .DISPENSE_CYCLES(D)
    ) dut (
        .clk(clk),
        .reset(reset),
        .req(req),
        .sel(sel),
        .credit(credit),
`ifdef VEND_STOCK_EN
        .restock_valid(restock_valid),
        .restock_prod(restock_prod),
        .restock_qty(restock_qty),
`endif
        .gnt(gnt),
        .motor_on(motor_on),
        .motor_prod(motor_prod),
        .done(done),
        .change(change),
        .reject(reject),
        .reject_reason(reject_reason)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic int price_of(input int s);
        case (s)
            0:       return 1;
            1:       return 2;
            default: return 3;
        endcase
    endfunction

    // Model: age counts cycles since capture (0 = idle); the timeline follows the latency rules.
    int age, m_idx, m_sel, m_credit, m_reason, m_rr, dec_p, c;
    bit m_ok;
    int stock[4];

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            age  = 0;
            m_rr = 0;
            m_ok = 1'b0;
            for (int p = 0; p < 4; p++) stock[p] = 3;
        end else begin
            dec_p = -1;
            if (age == 0) begin
                for (int k = 0; k < N; k++) begin
                    c = (m_rr + k) % N;
                    if (age == 0 && req[c]) begin
                        m_idx    = c;
                        m_sel    = int'(sel[2*c +: 2]);
                        m_credit = int'(credit[CW*c +: CW]);
                        age      = 1;
                    end
                end
            end else if (age == 1) begin
                if (STOCK_EN && stock[m_sel] == 0) begin
                    m_ok = 1'b0; m_reason = 2;
                end else if (m_credit < price_of(m_sel)) begin
                    m_ok = 1'b0; m_reason = 1;
                end else begin
                    m_ok = 1'b1;
                end
                age = 2;
            end else if (age == (m_ok ? 2 + D : 2)) begin
                m_rr = (m_idx + 1) % N;
                if (m_ok) dec_p = m_sel;
                age = 0;
            end else begin
                age++;
            end
`ifdef VEND_STOCK_EN
            if (restock_valid) begin
                stock[restock_prod] = stock[restock_prod] + int'(restock_qty);
                if (stock[restock_prod] > 15) stock[restock_prod] = 15;
            end
`endif
            if (dec_p >= 0) stock[dec_p]--;
        end
    end

    always @(negedge clk) begin
        if (reset === 1'b0) begin
            bit e_motor, e_done, e_rej;
            e_motor = (age >= 2) && m_ok && (age <= 1 + D);
            e_done  = m_ok && (age == 2 + D);
            e_rej   = !m_ok && (age == 2);
            check("m_gnt", gnt, (age > 0) ? (32'd1 << m_idx) : 32'd0);
            check("m_gnt_onehot", 32'($countones(gnt) <= 1), 32'd1);
            check("m_motor_on", motor_on, e_motor);
            if (e_motor) check("m_motor_prod", motor_prod, m_sel);
            check("m_done", done, e_done);
            check("m_change", change, e_done ? (m_credit - price_of(m_sel)) : 0);
            check("m_reject", reject, e_rej);
            check("m_reason", reject_reason, e_rej ? m_reason : 0);
        end
    end

    // Starts and ends just after a negedge; expectations are hand-computed by the caller.
    task automatic run_txn(input int p, input int s, input int cr, input bit zap,
                           input bit exp_ok, input int exp_val);
        int  cyc, motors;
        bit  seen;
        sel[2*p +: 2]     = 2'(s);
        credit[CW*p +: CW] = CW'(cr);
        req[p]            = 1'b1;
        cyc = 0; motors = 0; seen = 1'b0;
        while (!seen && cyc < 20) begin
            @(negedge clk);
            cyc++;
            if (cyc == 1) check("t_gnt_first", gnt, 32'd1 << p);
            if (zap && cyc == 2) credit[CW*p +: CW] = '0;
            if (motor_on) begin
                motors++;
                check("t_prod", motor_prod, s);
            end
            if (done || reject) seen = 1'b1;
        end
        check("t_finished", seen, 1);
        check("t_latency", cyc, exp_ok ? 2 + D : 2);
        check("t_motor_cycles", motors, exp_ok ? D : 0);
        if (exp_ok) begin
            check("t_done", done, 1);
            check("t_change", change, exp_val);
        end else begin
            check("t_reject", reject, 1);
            check("t_reason", reject_reason, exp_val);
        end
        req[p] = 1'b0;
        @(negedge clk);
    endtask

    task automatic wait_done(input int exp_gnt, input int exp_change);
        int cyc;
        cyc = 0;
        while (!done && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        check("w_seen_done", done, 1);
        check("w_gnt", gnt, exp_gnt);
        check("w_change", change, exp_change);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        req = '0; sel = '0; credit = '0;
`ifdef VEND_STOCK_EN
        restock_valid = 1'b0; restock_prod = '0; restock_qty = '0;
`endif
        reset = 1'b0;
        #1 reset = 1'b1;
        @(negedge clk);
        check("r_gnt", gnt, 0);
        check("r_motor", motor_on, 0);
        check("r_done_rej", {done, reject}, 0);
        @(negedge clk);
        reset = 1'b0;

        // Single panel 0, product 2 (price 3), credit 5 -> change 2.
        run_txn(0, 2, 5, 1'b0, 1'b1, 2);

        // Reset in the middle of dispensing drops everything at once.
        sel[1:0] = 2'd2; credit[3:0] = 4'd5; req[0] = 1'b1;
        repeat (4) @(negedge clk);
        check("a_motor_before", motor_on, 1);
        #2 reset = 1'b1;
        #1;
        check("a_motor", motor_on, 0);
        check("a_gnt", gnt, 0);
        check("a_done", done, 0);
        check("a_reject", reject, 0);
        req = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Both panels: rr pointer back at 0 so panel 0 first, then panel 1.
        sel = {2'd3, 2'd0}; credit = {4'd4, 4'd3}; req = 2'b11;
        wait_done(1, 2);
        req[0] = 1'b0;
        @(negedge clk);
        wait_done(2, 1);
        req[1] = 1'b0;
        @(negedge clk);

        // Panel 1 with no credit for product 0 -> reason 01.
        run_txn(1, 0, 0, 1'b0, 1'b0, 1);
        // Credit zeroed after capture: captured 7 - price 3 = 4.
        run_txn(0, 3, 7, 1'b1, 1'b1, 4);
        // Lone requester served back to back.
        run_txn(0, 0, 1, 1'b0, 1'b1, 0);

`ifdef VEND_STOCK_EN
        do_reset();
        repeat (3) run_txn(0, 1, 5, 1'b0, 1'b1, 3);
        run_txn(0, 1, 5, 1'b0, 1'b0, 2);
        restock_valid = 1'b1; restock_prod = 2'd1; restock_qty = 4'd2;
        @(negedge clk);
        restock_valid = 1'b0;
        run_txn(0, 1, 5, 1'b0, 1'b1, 3);
        run_txn(1, 1, 2, 1'b0, 1'b1, 0);
        run_txn(0, 1, 9, 1'b0, 1'b0, 2);
`endif

        repeat (2) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
